pc_sequencer: RTL
=================

# pc_sequencer

Program-counter and branch-resolution stage directly upstream of the single-cycle arithmetic/memory datapath. Holds the architectural PC, drives it as `PCin`, and on each clock chooses the next PC. The next PC is PC+1, the zero-extended immediate target, or a register target, selected from the current opcode and the datapath's `flags`. A small run-control FSM handles start-up, stalls and HALT.

## Interface
Parameters:
- `RESET_PC`, 32'd0, PC value loaded on reset.
- `HALT_OPCODE`, 6'b111111, opcode that stops sequencing.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE and begin execution.
- `stall`  in  1  freeze PC and counters this cycle.
- `opcode`  in  6  current instruction opcode, from the datapath.
- `flags`  in  3  datapath flags: [0]=carry, [1]=zero, [2]=sign.
- `address`  in  32  zero-extended immediate, used as the absolute branch target.
- `reg_target`  in  32  register-sourced target for `br`.
- `PCin`  out  32  current PC, fed to instruction memory and the datapath.
- `running`  out  1  FSM is in RUN.
- `halted`  out  1  FSM is in HALT.
- `branch_taken`  out  1  combinational; the next PC is a branch target.
- `retired`  out  32  instructions retired (only present with `PC_RETIRE_COUNT_EN`).

## Operation
- **FSM states:** IDLE, RUN, HALT.
  - IDLE→RUN when `start`=1.
  - RUN→HALT when `opcode`==`HALT_OPCODE` and `stall`=0.
  - HALT is terminal; only reset exits it.
  - `start` is ignored outside IDLE.
- **Opcode decode** (decided encodings; condition, then next PC when taken):
  - 010000 `b`: always taken → `address`.
  - 010001 `br`: always taken → `reg_target`.
  - 010010 `bl`: always taken → `address`. The link write is done by the datapath.
  - 010011 `bz`: taken if zero=1 → `address`.
  - 010100 `bnz`: taken if zero=0 → `address`.
  - 010101 `bltz`: taken if sign=1 → `address`.
  - 010110 `bcy`: taken if carry=1 → `address`.
  - 010111 `bncy`: taken if carry=0 → `address`.
  - Any other opcode: not taken; next PC = PC+1.
- `branch_taken` is asserted only in RUN. It is 0 in IDLE and HALT, whatever the opcode.
- Arithmetic: PC+1 is a 32-bit add with the carry discarded. 32'hFFFFFFFF wraps to 0 and no flag is raised.
- Targets are used unmodified; there is no alignment or range checking.
- HALT instruction: PC does not advance and keeps the HALT instruction's address.

## Timing
- Reset (asynchronous, `reset`=0), takes effect immediately without waiting for a clock edge:
  - `PCin`=`RESET_PC`, state=IDLE, `running`=0, `halted`=0, `retired`=0.
  - `branch_taken`=0 because the state is IDLE.
- Reset asserted mid-execution aborts the current instruction; the PC update of that cycle is lost.
- Deassertion of `reset` is synchronous to `clk` (it uses the external synchronizer).
- Flags and opcode are sampled in the same cycle they are presented (single-cycle datapath). Branch resolution adds no latency: the new PC is visible one edge after decode.
- In RUN with `stall`=0, the PC updates on every rising edge.
- With `stall`=1 the following hold:
  - `PCin`, the state and `retired` are unchanged.
  - Halt detection is deferred: stall has priority over HALT.
- On the IDLE→RUN edge the PC is not updated. The first instruction executes at `RESET_PC` in the following cycle.
- A `start`=1 and `stall`=1 edge in IDLE still enters RUN.

## Configuration
- `PC_RETIRE_COUNT_EN` defined:
  - `retired` port exists.
  - It increments by 1 on each RUN edge with `stall`=0, including the HALT instruction's edge.
  - It wraps from 32'hFFFFFFFF to 0.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset and start:** reset low → `PCin`=0, `running`=0. Release reset, pulse `start` → `running`=1 next edge and `PCin` still 0. Then 3 non-branch opcodes → `PCin`=1,2,3.
- **Conditional branches:** at PC=5, `bz` with `address`=32'h40, zero=1 → `PCin`=32'h40 next edge. Repeat with zero=0 → `PCin`=6. Do the same for `bcy`/`bncy` against carry.
- **Register branch:** `br` with `reg_target`=32'h1234 → `PCin`=32'h1234, `branch_taken`=1 during decode.
- **Stall and HALT priority:** `stall`=1 for 4 cycles with `opcode`=`HALT_OPCODE` → `PCin` frozen, `halted`=0. Deassert stall → `halted`=1 next edge, `PCin` unchanged afterwards regardless of opcode.
- **Wrap and asynchronous reset:** force PC to 32'hFFFFFFFF, non-branch opcode → `PCin`=0. Drop `reset` mid-cycle → `PCin`=`RESET_PC` before the next edge, state IDLE.
- **Retire counter** (`PC_RETIRE_COUNT_EN`): 10 RUN edges with 2 of them stalled → `retired`=8.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and branch resolution for the single-cycle datapath.
// Holds the architectural PC, resolves branches from opcode and flags in the decode
// cycle, and runs a small IDLE/RUN/HALT control FSM.
// Optional feature: define PC_RETIRE_COUNT_EN to add the `retired` instruction counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic [5:0]  opcode,
    input  logic [2:0]  flags,
    input  logic [31:0] address,
    input  logic [31:0] reg_target,
    output logic [31:0] PCin,
    output logic        running,
    output logic        halted,
    output logic        branch_taken
`ifdef PC_RETIRE_COUNT_EN
    ,
    output logic [31:0] retired
`endif
);

    // Branch opcode encodings.
    localparam logic [5:0] OP_B    = 6'b010000;
    localparam logic [5:0] OP_BR   = 6'b010001;
    localparam logic [5:0] OP_BL   = 6'b010010;
    localparam logic [5:0] OP_BZ   = 6'b010011;
    localparam logic [5:0] OP_BNZ  = 6'b010100;
    localparam logic [5:0] OP_BLTZ = 6'b010101;
    localparam logic [5:0] OP_BCY  = 6'b010110;
    localparam logic [5:0] OP_BNCY = 6'b010111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_inc;
    logic [31:0] w_target;
    logic        w_cond_hit;
    logic        w_is_halt;
    logic        w_advance;

    logic w_carry;
    logic w_zero;
    logic w_sign;

    assign w_carry = flags[0];
    assign w_zero  = flags[1];
    assign w_sign  = flags[2];

    // Carry out of the increment is intentionally dropped so the PC wraps to zero.
    assign w_pc_inc  = r_pc + 32'd1;
    assign w_is_halt = (opcode == HALT_OPCODE);

    // A RUN cycle that is not stalled retires the instruction in decode.
    assign w_advance = (r_state == StRun) && !stall;

    // Decode: evaluate the branch condition and select the target source.
    always_comb begin
        w_cond_hit = 1'b0;
        w_target   = address;
        case (opcode)
            OP_B:    w_cond_hit = 1'b1;
            OP_BR: begin
                w_cond_hit = 1'b1;
                w_target   = reg_target;
            end
            OP_BL:   w_cond_hit = 1'b1;
            OP_BZ:   w_cond_hit = w_zero;
            OP_BNZ:  w_cond_hit = !w_zero;
            OP_BLTZ: w_cond_hit = w_sign;
            OP_BCY:  w_cond_hit = w_carry;
            OP_BNCY: w_cond_hit = !w_carry;
            default: w_cond_hit = 1'b0;
        endcase
        // The halt opcode never branches, even if it aliases a branch encoding.
        if (w_is_halt) begin
            w_cond_hit = 1'b0;
        end
    end

    // Next-state and next-PC selection for the run-control FSM.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            StIdle: begin
                // PC is held on the IDLE->RUN edge; first fetch is at RESET_PC.
                if (start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                // Stall has priority: halt detection waits until the stall clears.
                if (!stall) begin
                    if (w_is_halt) begin
                        w_state_next = StHalt;
                    end else if (w_cond_hit) begin
                        w_pc_next = w_target;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
            end
            StHalt: begin
                w_state_next = StHalt;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State and PC registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

`ifdef PC_RETIRE_COUNT_EN
    logic [31:0] r_retired;

    // Retired count: one per unstalled RUN edge, halt instruction included; wraps freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= 32'd0;
        end else if (w_advance) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`else
    logic w_unused_advance;
    assign w_unused_advance = w_advance;
`endif

    // Outputs decoded from the registered state.
    always_comb begin
        PCin         = r_pc;
        running      = (r_state == StRun);
        halted       = (r_state == StHalt);
        branch_taken = (r_state == StRun) && w_cond_hit;
    end

endmodule
